// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the RISC core and its program-load path.
// Also holds the boot-loader state encoding.
package imem_boot_loader_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int BOOT_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    DONE,
    ERROR
  } boot_state_t;

  function automatic logic is_loading(boot_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; the completed word
// is presented combinationally alongside the 4th byte.
module imem_boot_loader_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shreg_q, shreg_d;

  // Bytes enter at the top so the first byte ends up in bits [7:0].
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clear) begin
      idx_d   = '0;
      shreg_d = '0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = {byte_data, shreg_q[31:8]};
    end
  end

  assign word_valid = byte_valid && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, shreg_q[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a counted little-endian instruction image into IMEM, holding the core
// in reset until done. Define BOOT_CHECKSUM_EN for a trailing checksum byte.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int IMEM_DEPTH_WORDS = 1024,
  parameter int IMEM_ADDR_WIDTH  = $clog2(IMEM_DEPTH_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [IMEM_ADDR_WIDTH:0]   words_loaded
);

  boot_state_t                state_q, state_d;
  logic [7:0]                 cnt_lo_q, cnt_lo_d;
  logic [IMEM_ADDR_WIDTH:0]   n_q, n_d;
  logic [IMEM_ADDR_WIDTH:0]   wl_q, wl_d;
  logic                       we_q, we_d;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       cpu_rst_n_q, cpu_rst_n_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]                 sum_q, sum_d;
`endif

  logic        accept;
  logic        restart;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] hdr_count;

  assign rx_ready  = !rst && is_loading(state_q);
  assign accept    = rx_valid && rx_ready;
  assign hdr_count = {rx_data, cnt_lo_q};

  imem_boot_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_valid (accept && (state_q == DATA)),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    n_d      = n_q;
    wl_d     = wl_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    restart  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      HDR_LO: if (accept) begin
        cnt_lo_d = rx_data;
        state_d  = HDR_HI;
      end
      HDR_HI: if (accept) begin
        if (hdr_count == 16'd0 || hdr_count > 16'(IMEM_DEPTH_WORDS)) begin
          state_d = ERROR;
        end else begin
          n_d     = hdr_count[IMEM_ADDR_WIDTH:0];
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
`ifdef BOOT_CHECKSUM_EN
        sum_d = sum_q + rx_data;
`endif
        if (word_valid) begin
          we_d    = 1'b1;
          waddr_d = wl_q[IMEM_ADDR_WIDTH-1:0];
          wdata_d = word;
          wl_d    = wl_q + 1'b1;
          // Leave DATA on the same edge that registers the final write.
          if (wl_q + 1'b1 == n_q) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: if (accept) begin
        state_d = (8'(sum_q + rx_data) == 8'd0) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: if (start) begin
        restart = 1'b1;
        state_d = HDR_LO;
        wl_d    = '0;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      default: state_d = ERROR;
    endcase
    // Release the core only after a full cycle in DONE, dropping at once on restart.
    cpu_rst_n_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HDR_LO;
      cnt_lo_q    <= '0;
      n_q         <= '0;
      wl_q        <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      n_q         <= n_d;
      wl_q        <= wl_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = is_loading(state_q);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign words_loaded = wl_q;

endmodule
